rr_arb_mux: RTL

//  - Parametrised, registered N-source arbitrating multiplexer; successor to the 4:1 select mux.
//  - Picks one of NUM_IN valid/ready sources by round-robin and registers its data into a

---
 rtl/rr_arb_mux_if.sv | 26 ++
 rtl/rr_arb_mux.sv | 102 ++++++++++
 2 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: NUM_IN valid/ready sources with packed data, one registered output.
// slave is the arbiter side, master is the producer/consumer side.
interface rr_arb_mux_if #(
  parameter int N      = 32,
  parameter int NUM_IN = 4
);
  localparam int SELW = $clog2(NUM_IN);

  logic [NUM_IN-1:0]   in_valid;
  logic [NUM_IN*N-1:0] in_data;
  logic [NUM_IN-1:0]   in_ready;
  logic                out_valid;
  logic [N-1:0]        out_data;
  logic [SELW-1:0]     out_src;
  logic                out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered NUM_IN-source round-robin arbitrating mux with valid/ready backpressure.
// Define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module rr_arb_mux #(
  parameter int N      = 32,
  parameter int NUM_IN = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_arb_mux_if.slave  bus
);
  localparam int SELW = $clog2(NUM_IN);

  logic            load;
  logic            gnt_found;
  logic [SELW-1:0] gnt_idx;

  logic            valid_q, valid_d;
  logic [N-1:0]    data_q,  data_d;
  logic [SELW-1:0] src_q,   src_d;

  // The output stage can take a new word when empty or when it drains this cycle.
  assign load = ~valid_q | bus.out_ready;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_idx   = '0;
    // Descending scan: the last hit, i.e. the lowest index, wins.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = SELW'(i);
      end
    end
  end
`else
  logic [SELW-1:0] ptr_q, ptr_d;

  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    // Scan ptr+NUM_IN down to ptr+1 so the closest successor of ptr is the last hit; wrap by
    // subtracting NUM_IN so non-power-of-2 source counts never see an out-of-range index.
    for (int k = NUM_IN; k >= 1; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (bus.in_valid[SELW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SELW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load && gnt_found) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= SELW'(NUM_IN - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    bus.in_ready = '0;
    if (load && gnt_found && !rst) bus.in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        data_d = bus.in_data[int'(gnt_idx)*N +: N];
        src_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
endmodule
